// File: rtl/instr_mem.sv
// Single-port instruction/data memory with byte enables, valid/ready request
// port, one-deep registered read response and a post-reset zero-fill sequencer.
module instr_mem #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DEPTH  = 256
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    input  logic [DATA_W/8-1:0] req_be,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                rsp_err,
    output logic                wr_err,
    output logic                init_done
);

    localparam int unsigned     NB        = DATA_W / 8;
    localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    typedef enum logic {
        S_INIT,
        S_RUN
    } state_t;

    state_t              r_state;
    logic [ADDR_W-1:0]   r_cnt;
    logic                r_rsp_valid;
    logic [DATA_W-1:0]   r_rsp_rdata;
    logic                r_rsp_err;
    logic                r_wr_err;
    logic                r_init_done;
    logic [DATA_W-1:0]   r_mem [DEPTH];

    logic w_in_range;
    logic w_accept;
    logic w_rd;
    logic w_wr_ok;
    logic w_wr_bad;

    // One extra address bit so DEPTH == 2^ADDR_W compares without truncation.
    assign w_in_range = {1'b0, req_addr} < DEPTH_EXT;
    assign req_ready  = r_init_done && (!r_rsp_valid || rsp_ready);
    assign w_accept   = req_valid && req_ready;
    assign w_rd       = w_accept && !req_we;
    assign w_wr_ok    = w_accept && req_we && w_in_range;
    assign w_wr_bad   = w_accept && req_we && !w_in_range;

    assign rsp_valid  = r_rsp_valid;
    assign rsp_rdata  = r_rsp_rdata;
    assign rsp_err    = r_rsp_err;
    assign wr_err     = r_wr_err;
    assign init_done  = r_init_done;

    always_ff @(posedge clk) begin
        if (r_state == S_INIT) begin
            r_mem[r_cnt] <= '0;
        end else if (w_wr_ok) begin
            for (int unsigned k = 0; k < NB; k++) begin
                if (req_be[k]) begin
                    r_mem[req_addr][8*k +: 8] <= req_wdata[8*k +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_INIT;
            r_cnt       <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
            r_wr_err    <= 1'b0;
            r_init_done <= 1'b0;
        end else begin
            case (r_state)
                S_INIT: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == LAST_ADDR) begin
                        r_state     <= S_RUN;
                        r_init_done <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (w_rd) begin
                        r_rsp_valid <= 1'b1;
                        r_rsp_rdata <= w_in_range ? r_mem[req_addr] : '0;
                        r_rsp_err   <= !w_in_range;
                    end else if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                    end
                    if (w_wr_bad) begin
                        r_wr_err <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_INIT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_mem.sv
// Directed bench for instr_mem: DUT A uses DEPTH=256, DUT B uses DEPTH=200.
module tb_instr_mem;

    logic        clk;

    logic        a_rst_n, a_req_valid, a_req_we, a_rsp_ready;
    logic [7:0]  a_req_addr;
    logic [31:0] a_req_wdata;
    logic [3:0]  a_req_be;
    logic        a_req_ready, a_rsp_valid, a_rsp_err, a_wr_err, a_init_done;
    logic [31:0] a_rsp_rdata;

    logic        b_rst_n, b_req_valid, b_req_we, b_rsp_ready;
    logic [7:0]  b_req_addr;
    logic [31:0] b_req_wdata;
    logic [3:0]  b_req_be;
    logic        b_req_ready, b_rsp_valid, b_rsp_err, b_wr_err, b_init_done;
    logic [31:0] b_rsp_rdata;

    int n_tests;
    int n_fail;

    instr_mem #(.DATA_W(32), .ADDR_W(8), .DEPTH(256)) u_dut_a (
        .clk(clk), .reset(a_rst_n),
        .req_valid(a_req_valid), .req_ready(a_req_ready), .req_we(a_req_we),
        .req_addr(a_req_addr), .req_wdata(a_req_wdata), .req_be(a_req_be),
        .rsp_valid(a_rsp_valid), .rsp_ready(a_rsp_ready), .rsp_rdata(a_rsp_rdata),
        .rsp_err(a_rsp_err), .wr_err(a_wr_err), .init_done(a_init_done)
    );

    instr_mem #(.DATA_W(32), .ADDR_W(8), .DEPTH(200)) u_dut_b (
        .clk(clk), .reset(b_rst_n),
        .req_valid(b_req_valid), .req_ready(b_req_ready), .req_we(b_req_we),
        .req_addr(b_req_addr), .req_wdata(b_req_wdata), .req_be(b_req_be),
        .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_rdata(b_rsp_rdata),
        .rsp_err(b_rsp_err), .wr_err(b_wr_err), .init_done(b_init_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic a_write(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] be);
        a_req_valid = 1'b1; a_req_we = 1'b1; a_req_addr = addr; a_req_wdata = data; a_req_be = be;
        @(posedge clk); #1;
        a_req_valid = 1'b0; a_req_we = 1'b0;
    endtask

    task automatic a_read(input logic [7:0] addr);
        a_req_valid = 1'b1; a_req_we = 1'b0; a_req_addr = addr;
        @(posedge clk); #1;
        a_req_valid = 1'b0;
    endtask

    task automatic b_write(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] be);
        b_req_valid = 1'b1; b_req_we = 1'b1; b_req_addr = addr; b_req_wdata = data; b_req_be = be;
        @(posedge clk); #1;
        b_req_valid = 1'b0; b_req_we = 1'b0;
    endtask

    task automatic b_read(input logic [7:0] addr);
        b_req_valid = 1'b1; b_req_we = 1'b0; b_req_addr = addr;
        @(posedge clk); #1;
        b_req_valid = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        n_tests++;
        if ({a_req_ready, a_rsp_valid, a_rsp_rdata, a_rsp_err, a_wr_err, a_init_done} !== 37'd0) begin
            n_fail++;
            $display("FAIL reset_a: rdy=%b vld=%b data=%h err=%b werr=%b done=%b, expected all 0",
                     a_req_ready, a_rsp_valid, a_rsp_rdata, a_rsp_err, a_wr_err, a_init_done);
        end
        n_tests++;
        if ({b_req_ready, b_rsp_valid, b_rsp_rdata, b_rsp_err, b_wr_err, b_init_done} !== 37'd0) begin
            n_fail++;
            $display("FAIL reset_b: rdy=%b vld=%b data=%h err=%b werr=%b done=%b, expected all 0",
                     b_req_ready, b_rsp_valid, b_rsp_rdata, b_rsp_err, b_wr_err, b_init_done);
        end
    endtask

    task automatic test_init();
        int cycles = 0;
        int b_cyc = 0;
        bit bad = 1'b0;
        a_rst_n = 1'b1; b_rst_n = 1'b1;
        a_rsp_ready = 1'b1; b_rsp_ready = 1'b1;
        a_req_valid = 1'b1; a_req_we = 1'b0; a_req_addr = 8'd5;
        while (cycles < 300 && a_init_done !== 1'b1) begin
            @(posedge clk); #1;
            cycles++;
            if (b_init_done === 1'b1 && b_cyc == 0) b_cyc = cycles;
            if (a_init_done !== 1'b1 && (a_req_ready !== 1'b0 || a_rsp_valid !== 1'b0)) bad = 1'b1;
        end
        n_tests++;
        if (cycles != 256 || a_init_done !== 1'b1) begin
            n_fail++;
            $display("FAIL init_len_a: init_done=%b after %0d cycles, expected 1 after 256", a_init_done, cycles);
        end
        n_tests++;
        if (b_cyc != 200) begin
            n_fail++;
            $display("FAIL init_len_b: init_done rose after %0d cycles, expected 200", b_cyc);
        end
        n_tests++;
        if (bad) begin
            n_fail++;
            $display("FAIL init_blocked: req_ready or rsp_valid was 1 during init, expected 0");
        end
        n_tests++;
        if (a_req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL init_ready: req_ready=%b, expected 1", a_req_ready);
        end
        @(posedge clk); #1;
        a_req_valid = 1'b0;
        n_tests++;
        if (a_rsp_valid !== 1'b1 || a_rsp_rdata !== 32'h0 || a_rsp_err !== 1'b0) begin
            n_fail++;
            $display("FAIL init_first_rsp: vld=%b data=%h err=%b, expected 1 00000000 0",
                     a_rsp_valid, a_rsp_rdata, a_rsp_err);
        end
        @(posedge clk); #1;
        n_tests++;
        if (a_rsp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL init_drain: rsp_valid=%b, expected 0", a_rsp_valid);
        end
    endtask

    task automatic test_byte_en();
        a_write(8'd3, 32'hAABBCCDD, 4'b1111);
        n_tests++;
        if (a_rsp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL write_no_rsp: rsp_valid=%b, expected 0", a_rsp_valid);
        end
        a_write(8'd3, 32'h11223344, 4'b0101);
        a_read(8'd3);
        n_tests++;
        if (a_rsp_valid !== 1'b1 || a_rsp_rdata !== 32'hAA22CC44 || a_rsp_err !== 1'b0) begin
            n_fail++;
            $display("FAIL byte_en_merge: vld=%b data=%h err=%b, expected 1 aa22cc44 0",
                     a_rsp_valid, a_rsp_rdata, a_rsp_err);
        end
        a_write(8'd3, 32'hFFFFFFFF, 4'b0000);
        a_read(8'd3);
        n_tests++;
        if (a_rsp_valid !== 1'b1 || a_rsp_rdata !== 32'hAA22CC44) begin
            n_fail++;
            $display("FAIL byte_en_zero: vld=%b data=%h, expected 1 aa22cc44", a_rsp_valid, a_rsp_rdata);
        end
    endtask

    task automatic test_back_pressure();
        for (int i = 0; i < 8; i++) a_write(8'(i), 32'(i), 4'hF);
        a_rsp_ready = 1'b0;
        a_req_valid = 1'b1; a_req_we = 1'b0; a_req_addr = 8'd1;
        @(posedge clk); #1;
        a_req_addr = 8'd2;
        #1;
        for (int s = 0; s < 3; s++) begin
            n_tests++;
            if (a_rsp_valid !== 1'b1 || a_rsp_rdata !== 32'h1 || a_req_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_hold_%0d: vld=%b data=%h rdy=%b, expected 1 00000001 0",
                         s, a_rsp_valid, a_rsp_rdata, a_req_ready);
            end
            @(posedge clk); #1;
        end
        a_rsp_ready = 1'b1;
        #1;
        n_tests++;
        if (a_req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_release_ready: req_ready=%b, expected 1", a_req_ready);
        end
        @(posedge clk); #1;
        a_req_valid = 1'b0;
        n_tests++;
        if (a_rsp_valid !== 1'b1 || a_rsp_rdata !== 32'h2 || a_rsp_err !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_next_rsp: vld=%b data=%h err=%b, expected 1 00000002 0",
                     a_rsp_valid, a_rsp_rdata, a_rsp_err);
        end
        @(posedge clk); #1;
        n_tests++;
        if (a_rsp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_drain: rsp_valid=%b, expected 0", a_rsp_valid);
        end
    endtask

    task automatic test_back_to_back();
        a_rsp_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            a_req_valid = 1'b1; a_req_we = 1'b0; a_req_addr = 8'(i);
            #1;
            n_tests++;
            if (a_req_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL b2b_ready_%0d: req_ready=%b, expected 1", i, a_req_ready);
            end
            @(posedge clk); #1;
            n_tests++;
            if (a_rsp_valid !== 1'b1 || a_rsp_rdata !== 32'(i) || a_rsp_err !== 1'b0) begin
                n_fail++;
                $display("FAIL b2b_rsp_%0d: vld=%b data=%h err=%b, expected 1 %h 0",
                         i, a_rsp_valid, a_rsp_rdata, a_rsp_err, 32'(i));
            end
        end
        a_req_valid = 1'b0;
        @(posedge clk); #1;
        n_tests++;
        if (a_rsp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_drain: rsp_valid=%b, expected 0", a_rsp_valid);
        end
    endtask

    task automatic test_out_of_range();
        b_rsp_ready = 1'b1;
        b_write(8'd122, 32'h00000012, 4'hF);
        b_write(8'd50,  32'h00000034, 4'hF);
        b_write(8'd199, 32'h000000C7, 4'hF);
        n_tests++;
        if (b_wr_err !== 1'b0) begin
            n_fail++;
            $display("FAIL oor_wr_err_clear: wr_err=%b, expected 0", b_wr_err);
        end
        b_write(8'd250, 32'hDEADBEEF, 4'hF);
        n_tests++;
        if (b_wr_err !== 1'b1 || b_rsp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL oor_wr_err_set: wr_err=%b vld=%b, expected 1 0", b_wr_err, b_rsp_valid);
        end
        b_read(8'd250);
        n_tests++;
        if (b_rsp_valid !== 1'b1 || b_rsp_rdata !== 32'h0 || b_rsp_err !== 1'b1) begin
            n_fail++;
            $display("FAIL oor_rd_250: vld=%b data=%h err=%b, expected 1 00000000 1",
                     b_rsp_valid, b_rsp_rdata, b_rsp_err);
        end
        b_read(8'd200);
        n_tests++;
        if (b_rsp_valid !== 1'b1 || b_rsp_rdata !== 32'h0 || b_rsp_err !== 1'b1) begin
            n_fail++;
            $display("FAIL oor_rd_200: vld=%b data=%h err=%b, expected 1 00000000 1",
                     b_rsp_valid, b_rsp_rdata, b_rsp_err);
        end
        b_read(8'd199);
        n_tests++;
        if (b_rsp_valid !== 1'b1 || b_rsp_rdata !== 32'hC7 || b_rsp_err !== 1'b0) begin
            n_fail++;
            $display("FAIL oor_rd_199: vld=%b data=%h err=%b, expected 1 000000c7 0",
                     b_rsp_valid, b_rsp_rdata, b_rsp_err);
        end
        b_read(8'd122);
        n_tests++;
        if (b_rsp_rdata !== 32'h12 || b_rsp_err !== 1'b0) begin
            n_fail++;
            $display("FAIL oor_alias_122: data=%h err=%b, expected 00000012 0", b_rsp_rdata, b_rsp_err);
        end
        b_read(8'd50);
        n_tests++;
        if (b_rsp_rdata !== 32'h34 || b_rsp_err !== 1'b0) begin
            n_fail++;
            $display("FAIL oor_alias_50: data=%h err=%b, expected 00000034 0", b_rsp_rdata, b_rsp_err);
        end
        repeat (3) @(posedge clk);
        #1;
        n_tests++;
        if (b_wr_err !== 1'b1) begin
            n_fail++;
            $display("FAIL oor_wr_err_sticky: wr_err=%b, expected 1", b_wr_err);
        end
    endtask

    task automatic test_reset_mid();
        int cycles = 0;
        a_rsp_ready = 1'b0;
        a_read(8'd6);
        n_tests++;
        if (a_rsp_valid !== 1'b1 || a_rsp_rdata !== 32'h6) begin
            n_fail++;
            $display("FAIL rst_mid_pre: vld=%b data=%h, expected 1 00000006", a_rsp_valid, a_rsp_rdata);
        end
        #2;
        a_rst_n = 1'b0; b_rst_n = 1'b0;
        #1;
        n_tests++;
        if ({a_req_ready, a_rsp_valid, a_rsp_rdata, a_rsp_err, a_wr_err, a_init_done} !== 37'd0) begin
            n_fail++;
            $display("FAIL rst_mid_async_a: rdy=%b vld=%b data=%h err=%b werr=%b done=%b, expected all 0",
                     a_req_ready, a_rsp_valid, a_rsp_rdata, a_rsp_err, a_wr_err, a_init_done);
        end
        n_tests++;
        if ({b_req_ready, b_rsp_valid, b_rsp_rdata, b_rsp_err, b_wr_err, b_init_done} !== 37'd0) begin
            n_fail++;
            $display("FAIL rst_mid_async_b: rdy=%b vld=%b data=%h err=%b werr=%b done=%b, expected all 0",
                     b_req_ready, b_rsp_valid, b_rsp_rdata, b_rsp_err, b_wr_err, b_init_done);
        end
        a_rst_n = 1'b1; b_rst_n = 1'b1;
        a_rsp_ready = 1'b1;
        while (cycles < 300 && a_init_done !== 1'b1) begin
            @(posedge clk); #1;
            cycles++;
        end
        n_tests++;
        if (cycles != 256 || a_init_done !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_mid_reinit: init_done=%b after %0d cycles, expected 1 after 256", a_init_done, cycles);
        end
        a_read(8'd6);
        n_tests++;
        if (a_rsp_valid !== 1'b1 || a_rsp_rdata !== 32'h0 || a_rsp_err !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid_cleared: vld=%b data=%h err=%b, expected 1 00000000 0",
                     a_rsp_valid, a_rsp_rdata, a_rsp_err);
        end
        b_read(8'd199);
        n_tests++;
        if (b_rsp_valid !== 1'b1 || b_rsp_rdata !== 32'h0 || b_wr_err !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid_b_cleared: vld=%b data=%h werr=%b, expected 1 00000000 0",
                     b_rsp_valid, b_rsp_rdata, b_wr_err);
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        a_rst_n = 1'b0; a_req_valid = 1'b0; a_req_we = 1'b0; a_rsp_ready = 1'b0;
        a_req_addr = '0; a_req_wdata = '0; a_req_be = '0;
        b_rst_n = 1'b0; b_req_valid = 1'b0; b_req_we = 1'b0; b_rsp_ready = 1'b0;
        b_req_addr = '0; b_req_wdata = '0; b_req_be = '0;

        test_reset();
        test_init();
        test_byte_en();
        test_back_pressure();
        test_back_to_back();
        test_out_of_range();
        test_reset_mid();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_mem.md
# instr_mem

Parametrised single-port instruction/data memory with byte-write enables, a valid/ready request port and a registered, back-pressurable read-response port. After reset, a built-in init sequencer clears every word to zero. It sits between the fetch stage (or a loader) and the PC pipeline register. It is the generalised successor of the 8×8 scratch memory, adding configurable width and depth, handshaking and range checking.

## Interface
- DATA_W, 32, word width in bits; multiple of 8
- ADDR_W, 8, word-address width
- DEPTH, 256, number of words; 1 ≤ DEPTH ≤ 2^ADDR_W
- clk  in  1  single clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  request accepted this cycle when req_valid && req_ready
- req_we  in  1  1 = write, 0 = read
- req_addr  in  ADDR_W  word address
- req_wdata  in  DATA_W  write data
- req_be  in  DATA_W/8  byte enables for writes; bit k covers bits 8k+7:8k
- rsp_valid  out  1  read data available
- rsp_ready  in  1  consumer takes response when rsp_valid && rsp_ready
- rsp_rdata  out  DATA_W  read data
- rsp_err  out  1  response is for an out-of-range address (addr ≥ DEPTH)
- wr_err  out  1  sticky flag: an out-of-range write was dropped
- init_done  out  1  memory clear complete; port usable

## Operation
- FSM states: INIT and RUN. Reset forces INIT with init counter = 0.
- INIT:
  - Each cycle writes 0 to word[counter], then increments the counter.
  - After the write to word DEPTH-1, moves to RUN.
  - req_ready = 0 throughout INIT.
- RUN: req_ready = init_done && (!rsp_valid || rsp_ready). The response slot is one entry deep, and a new read may be accepted in the same cycle the old response drains.
- Accepted write, addr < DEPTH:
  - Updates only the bytes with req_be set; the other bytes keep their value.
  - req_be = 0 is a legal no-op.
  - Produces no response.
- Accepted write, addr ≥ DEPTH: memory unchanged; wr_err set to 1 and held until reset.
- Accepted read, addr < DEPTH: rsp_rdata = word[addr], rsp_err = 0.
- Accepted read, addr ≥ DEPTH: rsp_rdata = 0, rsp_err = 1.
- Response hold: rsp_valid, rsp_rdata and rsp_err stay stable while rsp_valid && !rsp_ready.
- Response drain: when rsp_ready && rsp_valid and no new read is accepted, rsp_valid falls to 0.
- Address compare: req_addr is zero-extended and compared against DEPTH. No wrap-around and no truncation.

## Timing
- Reset values:
  - req_ready = 0, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, wr_err = 0, init_done = 0.
  - The FSM is in INIT.
- Reset deassertion is sampled at the next rising edge.
  - INIT spans exactly DEPTH cycles.
  - init_done rises after the DEPTH-th edge and stays 1 until reset.
- Read latency is 1 cycle. A read accepted at edge N gives rsp_valid = 1 and valid data after edge N.
- Write-then-read: a write accepted at edge N is visible to a read accepted at edge N+1.
- Throughput: with rsp_ready held at 1, one read per cycle is accepted back-to-back.
- Reset asserted mid-operation:
  - All outputs return immediately to their reset values and any pending response is lost.
  - Init restarts from word 0.
- Requests presented while init_done = 0 are not accepted and have no effect.

## Test plan
- Init: with DEPTH=256, release reset, hold req_valid=1 (read addr 5). init_done rises after exactly 256 cycles. The first response is rsp_rdata=0, rsp_err=0.
- Byte enables:
  - Write addr 3 with data 0xAABBCCDD, be=1111.
  - Then write addr 3 with data 0x11223344, be=0101.
  - Read addr 3 returns 0xAA22CC44.
- Back-pressure:
  - Read addr 1 (holds 0x1), with rsp_ready=0 for 3 cycles.
  - rsp_valid stays 1 with rsp_rdata=0x1, and req_ready=0 while the slot is full.
  - Raise rsp_ready together with a read of addr 2 (holds 0x2). The next-cycle response is 0x2 with no bubble.
- Out of range, with DEPTH=200:
  - Write addr 250: memory unchanged and wr_err=1 sticky.
  - Read addr 250: rsp_rdata=0, rsp_err=1.
  - Read addr 199: rsp_err=0.
- Back-to-back: 8 consecutive reads of addr 0..7 with rsp_ready=1. Responses arrive on 8 consecutive cycles in order and match the written values.
- Reset mid-stream: assert reset while rsp_valid=1.
  - Outputs go to reset values asynchronously.
  - After release, 256 init cycles follow.
  - A read of a previously written address returns 0.
